// File: rtl/lane_latch_loader.sv
// Serial-to-parallel loader for the per-lane latch array: collects M bits, then
// drives lane data/enables through a setup -> transparent -> hold sequence.
module lane_latch_loader #(
  parameter int M           = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic         i_clk,
  input  logic         i_arst,
  input  logic         i_valid,
  input  logic         i_bit,
  input  logic [M-1:0] i_lane_mask,
  output logic         o_ready,
  output logic [M-1:0] o_a,
  output logic [M-1:0] o_en,
  output logic         o_done,
  output logic         o_busy
);

  localparam int CW = $clog2(M);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(M - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    SETUP   = 3'd2,
    OPEN    = 3'd3,
    CLOSE   = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [M-1:0]  sh_r, sh_s;
  logic [M-1:0]  mask_r, mask_s;
  logic [M-1:0]  a_r, a_s;
  logic [M-1:0]  en_r, en_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [HW-1:0] hold_r, hold_s;
  logic          ready_r, ready_s;
  logic          done_r, done_s;
  logic          busy_r, busy_s;
  logic          hs_s;

  // Next-state logic; every output register is computed from the next state so
  // that it is valid in the same cycle as the state it describes.
  always_comb begin
    state_s = state_r;
    sh_s    = sh_r;
    mask_s  = mask_r;
    a_s     = a_r;
    cnt_s   = cnt_r;
    hold_s  = hold_r;
    hs_s    = i_valid & ready_r;

    case (state_r)
      IDLE: begin
        state_s = COLLECT;
      end
      COLLECT: begin
        if (hs_s) begin
          sh_s[cnt_r] = i_bit;
          if (cnt_r == LAST_CNT) begin
            // The final bit bypasses the shift register so o_a is complete in SETUP.
            a_s        = sh_r;
            a_s[M-1]   = i_bit;
            mask_s     = i_lane_mask;
            cnt_s      = '0;
            state_s    = SETUP;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          state_s = COLLECT;
        end
      end
      SETUP: begin
        hold_s  = HOLD_INIT;
        state_s = OPEN;
      end
      OPEN: begin
        if (hold_r == '0) begin
          state_s = CLOSE;
        end else begin
          hold_s = hold_r - HW'(1);
        end
      end
      CLOSE: begin
        state_s = COLLECT;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    ready_s = (state_s == COLLECT);
    busy_s  = (state_s != COLLECT);
    done_s  = (state_s == CLOSE);
    if (state_s == OPEN) begin
      en_s = mask_s;
    end else begin
      en_s = '0;
    end
  end

  // State and output registers; the async clear drops the enables immediately.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_r <= IDLE;
      sh_r    <= '0;
      mask_r  <= '0;
      a_r     <= '0;
      en_r    <= '0;
      cnt_r   <= '0;
      hold_r  <= '0;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      sh_r    <= sh_s;
      mask_r  <= mask_s;
      a_r     <= a_s;
      en_r    <= en_s;
      cnt_r   <= cnt_s;
      hold_r  <= hold_s;
      ready_r <= ready_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
    end
  end

  assign o_ready = ready_r;
  assign o_a     = a_r;
  assign o_en    = en_r;
  assign o_done  = done_r;
  assign o_busy  = busy_r;

endmodule
